// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: reset sequencing, run-cycle count, halt/timeout detection.
// Optional retired-instruction counter is enabled by defining MIPS_RUN_CTRL_RETIRE_EN.
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 100000,
    parameter int unsigned HALT_REPEAT = 8,
    parameter int unsigned PC_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             pc_valid,
`ifdef MIPS_RUN_CTRL_RETIRE_EN
    input  logic             retire,
    output logic [CNT_W-1:0] retire_count,
`endif
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  halt_pc
);

    localparam int unsigned RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned RPT_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RC_W-1:0]   hold_cnt;
    logic [RC_W-1:0]   hold_cnt_nxt;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_cnt_nxt;
    logic [PC_W-1:0]   last_pc;
    logic [PC_W-1:0]   last_pc_nxt;
    logic [CNT_W-1:0]  cycle_nxt;
    logic [PC_W-1:0]   halt_pc_nxt;
    logic              cpu_reset_nxt;
    logic              running_nxt;
    logic              done_nxt;
    logic              timeout_nxt;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
    logic [CNT_W-1:0]  retire_nxt;
`endif

    // Next-state, counter and output decode
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        rpt_cnt_nxt  = rpt_cnt;
        last_pc_nxt  = last_pc;
        cycle_nxt    = cycle_count;
        halt_pc_nxt  = halt_pc;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
        retire_nxt   = retire_count;
`endif

        unique case (state)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_nxt    = S_RST_HOLD;
                    hold_cnt_nxt = RC_W'(RST_CYCLES - 1);
                    rpt_cnt_nxt  = '0;
                    last_pc_nxt  = '0;
                    cycle_nxt    = '0;
                    halt_pc_nxt  = '0;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
                    retire_nxt   = '0;
`endif
                end
            end
            S_RST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt - RC_W'(1);
                end
            end
            S_RUN: begin
                cycle_nxt = cycle_count + CNT_W'(1);
`ifdef MIPS_RUN_CTRL_RETIRE_EN
                if (retire) begin
                    retire_nxt = retire_count + CNT_W'(1);
                end
`endif
                // A stalled cycle neither extends nor breaks the repeat run
                if (pc_valid) begin
                    if (pc_in == last_pc) begin
                        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                    end else begin
                        rpt_cnt_nxt = RPT_W'(1);
                        last_pc_nxt = pc_in;
                    end
                end
                // Halt takes priority over a timeout on the same edge
                if (rpt_cnt_nxt == RPT_W'(HALT_REPEAT)) begin
                    state_nxt   = S_HALTED;
                    halt_pc_nxt = last_pc_nxt;
                end else if (cycle_nxt == CNT_W'(MAX_CYCLES)) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        cpu_reset_nxt = (state_nxt != S_RUN);
        running_nxt   = (state_nxt == S_RUN);
        done_nxt      = (state_nxt == S_HALTED);
        timeout_nxt   = (state_nxt == S_TIMEOUT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            rpt_cnt      <= '0;
            last_pc      <= '0;
            cycle_count  <= '0;
            halt_pc      <= '0;
            cpu_reset    <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
            retire_count <= '0;
`endif
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            rpt_cnt      <= rpt_cnt_nxt;
            last_pc      <= last_pc_nxt;
            cycle_count  <= cycle_nxt;
            halt_pc      <= halt_pc_nxt;
            cpu_reset    <= cpu_reset_nxt;
            running      <= running_nxt;
            done         <= done_nxt;
            timeout      <= timeout_nxt;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
            retire_count <= retire_nxt;
`endif
        end
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the pipelined MIPS core; replaces hand-written reset/stimulus sequencing in benches and on board.
- Issues a parametrised-length reset pulse to the core, counts run cycles, and detects end of program: PC held on one value (jump-to-self) for HALT_REPEAT consecutive valid cycles.
- Enforces a cycle timeout.
- Sits between the top-level clock/reset and the mips core's reset input; observes the core's fetch PC.

Parameters:
- RST_CYCLES, 4: cycles cpu_reset is held high after start.
- CNT_W, 32: width of cycle_count.
- MAX_CYCLES, 100000: run cycles before timeout (must be < 2^CNT_W).
- HALT_REPEAT, 8: consecutive identical valid PCs that declare halt (>= 2).
- PC_W, 32: width of pc_in.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
- pc_in  in  PC_W  fetch-stage PC from core
- pc_valid  in  1  pc_in qualified this cycle (low during stall)
- cpu_reset  out  1  active-high reset driven to core
- running  out  1  high in RUN state
- done  out  1  high in HALTED state
- timeout  out  1  high in TIMEOUT state
- cycle_count  out  CNT_W  cycles spent in RUN for current/last run
- halt_pc  out  PC_W  PC value that triggered halt

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; cpu_reset=1; running=0; done=0; timeout=0; cycle_count=0; halt_pc=0; internal repeat counter=0.
  - Reset mid-run aborts immediately, no completion flag.
- FSM states: IDLE, RST_HOLD, RUN, HALTED, TIMEOUT.
- IDLE:
  - cpu_reset=1.
  - start -> RST_HOLD; clear cycle_count, repeat counter, halt_pc, done, timeout.
- RST_HOLD:
  - cpu_reset=1 for exactly RST_CYCLES cycles (counter from RST_CYCLES-1 down to 0).
  - Then -> RUN. cpu_reset falls on the same edge running rises.
- RUN:
  - cpu_reset=0; cycle_count += 1 every cycle, including the first RUN cycle.
  - If pc_valid: if pc_in == last captured PC, repeat counter +1, else repeat counter=1 and capture pc_in.
  - If !pc_valid: repeat counter and captured PC hold (stall is neither match nor break).
  - repeat counter reaching HALT_REPEAT -> HALTED next edge; halt_pc=captured PC.
  - cycle_count reaching MAX_CYCLES -> TIMEOUT.
  - Both conditions on the same edge -> HALTED wins.
  - start ignored in RUN and RST_HOLD.
- HALTED / TIMEOUT:
  - cpu_reset=1 (core frozen); cycle_count and halt_pc held; done or timeout held high.
  - start -> RST_HOLD (re-run, same clears as IDLE).
- Output rules:
  - Exactly one of running/done/timeout high outside IDLE/RST_HOLD.
  - All outputs registered; no combinational path from inputs to outputs.
- Counter saturation: cycle_count never wraps (timeout fires first).

Optional Feature:
- Macro MIPS_RUN_CTRL_RETIRE_EN.
- Defined:
  - Adds input retire (1 bit, one pulse per retired instruction) and output retire_count (CNT_W).
  - retire_count clears on entry to RST_HOLD, increments on retire only in RUN, holds otherwise, resets to 0.
  - Final value visible in HALTED/TIMEOUT.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset low 3 cycles, then high -> IDLE, cpu_reset=1, running=done=timeout=0, cycle_count=0.
- start pulse, RST_CYCLES=4 -> cpu_reset high exactly 4 cycles after start edge, then running=1, cycle_count=1 on first RUN edge.
- PC sequence 0x3000,0x3004,...,0x3010 then 0x3010 held valid 8 cycles -> done=1, halt_pc=0x3010, cpu_reset=1, cycle_count frozen.
- Same PC held but pc_valid toggled low every other cycle -> halt only after 8 valid matches; stalls do not reset count.
- MAX_CYCLES=50, PC incrementing every cycle -> timeout=1 at cycle_count=50, done=0.
- Reset driven low mid-RUN at cycle 20 -> next edge IDLE, all outputs at reset values; start in HALTED re-runs with cycle_count cleared.
